axil_cfg_master: RTL and testbench

- Synthesizable AXI4-lite master that sits directly upstream of the Garnet `axi4_slave_*` configuration port.
- Accepts single register read/write commands on a valid/ready command channel.
- Runs exactly one AXI4-lite transaction per command and returns the result on a valid/ready response channel.
- Replaces ad-hoc bench driving of `axil_ifc`; also reusable as an on-chip config sequencer front end.

---
 rtl/axil_cfg_pkg.sv | 37 +++
 rtl/axil_cfg_watchdog.sv | 39 +++
 rtl/axil_cfg_master.sv | 191 +++++++++++++++++++
 tb/tb_axil_cfg_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_cfg_pkg.sv
// Shared types for the AXI4-lite configuration master: FSM state encoding,
// AXI response codes, command/response bundles and a saturating counter helper.
package axil_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned AXIL_ADDR_W = 13;
  localparam int unsigned AXIL_DATA_W = 32;

  typedef struct packed {
    logic                   write;
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_DATA_W-1:0] data;
  } axil_cmd_t;

  typedef struct packed {
    logic                   write;
    logic [AXIL_DATA_W-1:0] data;
    logic [1:0]             resp;
  } axil_rsp_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axil_cfg_watchdog.sv
// Per-state wait counter: restarts whenever the master changes state and flags
// expiry on the TIMEOUT_CYCLES-th cycle spent in one AXI wait state.
module axil_cfg_watchdog
  import axil_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  axil_state_e i_state,
  output logic        o_expired
);

  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  axil_state_e r_prev;
  logic [15:0] r_cnt;
  logic        w_waiting;
  logic [15:0] w_cnt;

  // The first cycle of any state counts as zero, so the limit is per state entry.
  always_comb begin
    w_waiting = (i_state == WR) || (i_state == WR_RESP) ||
                (i_state == RD_ADDR) || (i_state == RD_DATA);
    w_cnt     = (i_state != r_prev) ? 16'd0 : r_cnt;
    o_expired = w_waiting && (w_cnt == LP_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev <= IDLE;
      r_cnt  <= 16'd0;
    end else begin
      r_prev <= i_state;
      r_cnt  <= w_waiting ? (w_cnt + 16'd1) : 16'd0;
    end
  end

endmodule

// File: rtl/axil_cfg_master.sv
// AXI4-lite master running one register read/write per command.
// Optional watchdog abort is enabled with `define AXIL_CFG_MASTER_TIMEOUT_EN.
module axil_cfg_master
  import axil_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic [7:0]            err_count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  axil_state_e r_state;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_timeout;

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid  & m_wready;
  assign w_b_hs  = m_bvalid  & m_bready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid  & m_rready;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  axil_cfg_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_state  (r_state),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Command FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_resp  <= RESP_OKAY;
      err_count <= 8'd0;
      busy      <= 1'b0;
      m_awaddr  <= {ADDR_WIDTH{1'b0}};
      m_awvalid <= 1'b0;
      m_wdata   <= {DATA_WIDTH{1'b0}};
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= {ADDR_WIDTH{1'b0}};
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else if (w_timeout) begin
      // Abandon the stalled transaction and report it as a slave error.
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_resp  <= RESP_SLVERR;
      rsp_valid <= 1'b1;
      err_count <= sat_inc8(err_count);
      r_state   <= RSP;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_write <= cmd_write;
            m_awaddr  <= cmd_addr;
            m_araddr  <= cmd_addr;
            m_wdata   <= cmd_data;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (cmd_write) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              r_state   <= WR;
            end else begin
              m_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (w_aw_hs) begin
            m_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            m_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            m_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (w_b_hs) begin
            m_bready  <= 1'b0;
            rsp_data  <= {DATA_WIDTH{1'b0}};
            rsp_resp  <= m_bresp;
            rsp_valid <= 1'b1;
            err_count <= (m_bresp != RESP_OKAY) ? sat_inc8(err_count) : err_count;
            r_state   <= RSP;
          end
        end
        RD_ADDR: begin
          if (w_ar_hs) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_r_hs) begin
            m_rready  <= 1'b0;
            rsp_data  <= m_rdata;
            rsp_resp  <= m_rresp;
            rsp_valid <= 1'b1;
            err_count <= (m_rresp != RESP_OKAY) ? sat_inc8(err_count) : err_count;
            r_state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b0;
          m_bready  <= 1'b0;
          m_arvalid <= 1'b0;
          m_rready  <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a small configurable AXI4-lite slave.
// Define AXIL_CFG_MASTER_TIMEOUT_EN to also exercise the watchdog abort.
module tb_axil_cfg_master;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_count;
  logic        busy;
  logic [12:0] m_awaddr, m_araddr;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0] m_wdata, m_rdata;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  axil_cfg_master #(
    .ADDR_WIDTH(13), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .err_count(err_count), .busy(busy),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // Slave knobs: cycles each valid waits before ready, response codes, B hold-off.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'd0;
  logic        b_hold = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        s_aw_got = 1'b0, s_w_got = 1'b0;
  int          n_aw = 0, n_w = 0, n_b = 0;
  wire         tb_aw_hs = m_awvalid & m_awready;
  wire         tb_w_hs  = m_wvalid & m_wready;
  wire         tb_ar_hs = m_arvalid & m_arready;

  assign m_awready = (aw_cnt >= aw_dly);
  assign m_wready  = (w_cnt >= w_dly);
  assign m_arready = (ar_cnt >= ar_dly);
  assign m_bresp   = s_bresp;

  // Slave model: ready delays, one B per AW+W pair, R one cycle after AR.
  always @(posedge clk) begin
    if (!reset_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_rdata <= 32'd0; m_rresp <= 2'b00;
    end else begin
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      if (tb_aw_hs) n_aw <= n_aw + 1;
      if (tb_w_hs) n_w <= n_w + 1;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        n_b <= n_b + 1;
      end
      if ((s_aw_got || tb_aw_hs) && (s_w_got || tb_w_hs) && !b_hold) begin
        m_bvalid <= 1'b1;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end else begin
        if (tb_aw_hs) s_aw_got <= 1'b1;
        if (tb_w_hs) s_w_got <= 1'b1;
      end
      if (tb_ar_hs) begin
        m_rvalid <= 1'b1;
        m_rdata  <= s_rdata;
        m_rresp  <= s_rresp;
      end else if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0;
      end
    end
  end

  int          n_vec = 0, n_err = 0;
  int          lat, ar_stall;
  logic        split_seen, first_aw, first_w, q_arv, q_write;
  logic [31:0] q_data;
  logic [1:0]  q_resp;
  int          b0, aw0, w0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [12:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = 32'd0;
  endtask

  // Called right after the accept edge; lat = negedges until rsp_valid is seen.
  task automatic wait_rsp(input logic [12:0] a, input logic [31:0] d);
    logic got = 1'b0;
    lat = 0; ar_stall = 0; split_seen = 1'b0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        first_aw = m_awvalid;
        first_w  = m_wvalid;
      end
      if (m_arvalid) begin
        if (!m_arready) ar_stall++;
        check_val("araddr_hold", 32'(m_araddr), 32'(a));
      end
      if (m_awvalid) check_val("awaddr_hold", 32'(m_awaddr), 32'(a));
      if (m_wvalid) check_val("wdata_hold", m_wdata, d);
      if (m_awvalid && !m_wvalid) split_seen = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    check_val("rsp_seen", 32'(got), 32'd1);
    q_data = rsp_data; q_resp = rsp_resp; q_write = rsp_write; q_arv = m_arvalid;
    @(negedge clk);
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input logic w, input logic [12:0] a, input logic [31:0] d);
    b0 = n_b; aw0 = n_aw; w0 = n_w;
    send_cmd(w, a, d);
    wait_rsp(a, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valids"},
              32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}), 32'd0);
    check_val({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 13'd0; cmd_data = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Minimum-latency write.
    run_cmd(1'b1, 13'h010, 32'hDEADBEEF);
    check_val("wr_first_awvalid", 32'(first_aw), 32'd1);
    check_val("wr_first_wvalid", 32'(first_w), 32'd1);
    check_val("wr_latency", 32'(lat), 32'd3);
    check_val("wr_rsp_write", 32'(q_write), 32'd1);
    check_val("wr_rsp_resp", 32'(q_resp), 32'd0);
    check_val("wr_rsp_data", q_data, 32'd0);
    check_val("wr_b_count", 32'(n_b - b0), 32'd1);

    // Read with a 5-cycle arready delay.
    ar_dly = 5; s_rdata = 32'h12345678;
    run_cmd(1'b0, 13'h014, 32'h0);
    check_val("rd_ar_stall", 32'(ar_stall), 32'd5);
    check_val("rd_latency", 32'(lat), 32'd8);
    check_val("rd_rsp_data", q_data, 32'h12345678);
    check_val("rd_rsp_resp", 32'(q_resp), 32'd0);
    check_val("rd_rsp_write", 32'(q_write), 32'd0);
    ar_dly = 0;

    // W completes 4 cycles before AW, then the reverse order.
    aw_dly = 4; w_dly = 0;
    run_cmd(1'b1, 13'h020, 32'hA5A55A5A);
    check_val("split_w_first_seen", 32'(split_seen), 32'd1);
    check_val("split_w_first_lat", 32'(lat), 32'd7);
    check_val("split_w_first_aw", 32'(n_aw - aw0), 32'd1);
    check_val("split_w_first_w", 32'(n_w - w0), 32'd1);
    check_val("split_w_first_b", 32'(n_b - b0), 32'd1);
    aw_dly = 0; w_dly = 2;
    run_cmd(1'b1, 13'h024, 32'h0000FFFF);
    check_val("split_aw_first_lat", 32'(lat), 32'd5);
    check_val("split_aw_first_b", 32'(n_b - b0), 32'd1);
    check_val("split_aw_first_w", 32'(n_w - w0), 32'd1);
    w_dly = 0;

    // DECERR responses: count, then saturate.
    s_bresp = 2'b11;
    for (int i = 0; i < 3; i++) run_cmd(1'b1, 13'h040, 32'(i));
    check_val("decerr_resp", 32'(q_resp), 32'd3);
    check_val("err_count_3", 32'(err_count), 32'd3);
    for (int i = 3; i < 300; i++) run_cmd(1'b1, 13'h044, 32'(i));
    check_val("err_count_sat", 32'(err_count), 32'd255);
    s_bresp = 2'b00;
    s_rresp = 2'b10; s_rdata = 32'hCAFEF00D;
    run_cmd(1'b0, 13'h048, 32'h0);
    check_val("rd_slverr_resp", 32'(q_resp), 32'd2);
    check_val("rd_slverr_data", q_data, 32'hCAFEF00D);
    check_val("err_count_hold", 32'(err_count), 32'd255);
    s_rresp = 2'b00;

    // Reset while waiting for B.
    b_hold = 1'b1;
    send_cmd(1'b1, 13'h030, 32'h11111111);
    begin
      int n = 0;
      while (!m_bready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check_val("wr_resp_bready", 32'(m_bready), 32'd1);
    check_val("wr_resp_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    @(negedge clk); reset_n = 1'b1; b_hold = 1'b0;
    @(posedge clk); #1;
    check_val("cmd_ready_after_abort", 32'(cmd_ready), 32'd1);
    run_cmd(1'b1, 13'h034, 32'h22222222);
    check_val("recover_lat", 32'(lat), 32'd3);
    check_val("recover_resp", 32'(q_resp), 32'd0);
    check_val("recover_err_count", 32'(err_count), 32'd0);

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    // arready never comes: abort after TB_TMO wait cycles.
    ar_dly = 100000; s_rdata = 32'h55555555;
    run_cmd(1'b0, 13'h050, 32'h0);
    check_val("tmo_latency", 32'(lat), 32'(TB_TMO + 1));
    check_val("tmo_resp", 32'(q_resp), 32'd2);
    check_val("tmo_data", q_data, 32'd0);
    check_val("tmo_arvalid", 32'(q_arv), 32'd0);
    check_val("tmo_err_count", 32'(err_count), 32'd1);
    ar_dly = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
